// File: rtl/ls_pkg.sv
// ls_pkg: opcode constants, state encoding and error codes for the load/store controller
package ls_pkg;
   localparam logic [1:0] OP_LOAD    = 2'b00;
   localparam logic [1:0] OP_NOP     = 2'b01;
   localparam logic [1:0] OP_ILLEGAL = 2'b10;
   localparam logic [1:0] OP_STORE   = 2'b11;
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WB} state_t;
endpackage

// File: rtl/ls_wait_timer.sv
// ls_wait_timer: counts memory request cycles and flags the last one that has no ack
module ls_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   input  logic ack,
   output logic expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n || clear) cnt <= '0;
      else if (enable && !ack) cnt <= cnt + 8'd1;
   end
   // cnt holds the number of completed request cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
   assign expired = enable & ~ack & (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/ls_control_fsm.sv
// ls_control_fsm: sequences LOAD/STORE/NOP/ILLEGAL instructions onto a memory request bus
module ls_control_fsm
   import ls_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              reg_write,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);
   state_t state, state_d;
   logic ready_q, done_q, err_q, done_d, err_d, accept, busy, expired;
   logic [1:0] code_q, code_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   ls_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk(clk), .rst_n(rst_n), .clear(accept), .enable(busy), .ack(mem_ack), .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_d;
         ready_q <= state_d == S_IDLE;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state == S_RD && mem_ack) rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      accept = instr_valid & ready_q;
      busy   = state == S_RD || state == S_WR;
      unique case (state)
         S_IDLE:  state_d = !accept ? S_IDLE : opcode == OP_LOAD ? S_RD : opcode == OP_STORE ? S_WR : S_IDLE;
         S_RD:    state_d = mem_ack ? S_WB : expired ? S_IDLE : S_RD;
         S_WR:    state_d = (mem_ack || expired) ? S_IDLE : S_WR;
         default: state_d = S_IDLE;
      endcase
      // done is registered one cycle early so it lands in the WB cycle alongside reg_write
      done_d = (accept && opcode == OP_NOP) || (busy && mem_ack);
      err_d  = (accept && opcode == OP_ILLEGAL) || expired;
      code_d = !err_d ? ERR_NONE : accept ? ERR_ILLEGAL : ERR_TIMEOUT;
   end

   always_comb begin
      instr_ready = ready_q;
      mem_read    = state == S_RD;
      mem_write   = state == S_WR;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
      reg_write   = state == S_WB;
      reg_wdata   = rdata_q;
      done        = done_q;
      err         = err_q;
      err_code    = code_q;
   end
endmodule

// File: doc/ls_control_fsm.md
LS_CONTROL_FSM -- requirements
Module: ls_control_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum request cycles without mem_ack (legal range 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1): the instruction handshake.
REQ-007 SHALL have ports opcode (input, 2), addr (input, ADDR_W) and wdata (input, DATA_W): the instruction fields.
REQ-008 SHALL have ports mem_read and mem_write (outputs, 1 each): the memory request strobes.
REQ-009 SHALL have ports mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the request payload.
REQ-010 SHALL have ports mem_ack (input, 1) and mem_rdata (input, DATA_W): the memory response.
REQ-011 SHALL have ports reg_write (output, 1) and reg_wdata (output, DATA_W): the register-file write-back.
REQ-012 SHALL have ports done (output, 1), err (output, 1) and err_code (output, 2): the per-instruction completion and error pulses.

Function
REQ-013 SHALL decode opcode as: 00 LOAD, 11 STORE, 01 NOP, 10 ILLEGAL.
REQ-014 SHALL implement the states IDLE, RD, WR and WB, with all outputs decoded from registered state or registered data (no combinational path from inputs to outputs).
REQ-015 SHALL drive instr_ready=1 only in IDLE, and SHALL accept an instruction when instr_valid & instr_ready at a rising edge, latching opcode, addr and wdata.
REQ-016 SHALL, on accepting LOAD, go to RD; on STORE, go to WR; on NOP, stay in IDLE and pulse done next cycle; on ILLEGAL, stay in IDLE and pulse err with err_code=01 next cycle.
REQ-017 SHALL, in RD, hold mem_read=1 with mem_addr equal to the latched addr; on mem_ack it SHALL capture mem_rdata and go to WB.
REQ-018 SHALL, in WB, assert reg_write=1 with reg_wdata equal to the captured data for exactly one cycle, pulse done in the same cycle, and then return to IDLE.
REQ-019 SHALL, in WR, hold mem_write=1 with mem_addr and mem_wdata latched; on mem_ack it SHALL return to IDLE and pulse done in the next cycle.
REQ-020 SHALL make the minimum LOAD latency: accept at edge t, RD in cycle t+1, ack in t+1, reg_write in cycle t+2.
REQ-021 SHALL count request cycles in RD or WR with an 8-bit counter cleared on state entry.
REQ-022 SHALL, if no ack has arrived by the TIMEOUT-th request cycle, drop the strobe, return to IDLE, and pulse err with err_code=10 with done=0.
REQ-023 SHALL let an ack on the final (TIMEOUT-th) cycle win over the timeout.
REQ-024 SHALL ignore mem_ack in IDLE and WB.
REQ-025 SHALL never assert mem_read and mem_write simultaneously, nor done and err simultaneously.
REQ-026 SHALL drive err_code=00 whenever err=0.

Reset
REQ-027 SHALL, while rst_n=0 at an edge, set state to IDLE and all outputs to 0 (mem_addr, mem_wdata, reg_wdata and err_code to 0), and clear the wait counter.
REQ-028 SHALL hold instr_ready=0 while rst_n=0 and SHALL accept no instruction in that cycle.
REQ-029 SHALL, on reset during RD, WR or WB, abandon the operation with no done, err or reg_write pulse afterwards.

Structure
REQ-030 SHALL place the opcode constants, state encoding and err_code values in the shared package ls_pkg.
REQ-031 SHALL implement the request timeout counter as the sub-module ls_wait_timer, with inputs clear, enable and ack and output expired.

Verification
REQ-032 SHALL be verified for LOAD: opcode=00, addr=0x3A, mem_ack on the 3rd RD cycle with rdata=0x5C -> mem_read high for 3 cycles, then one-cycle reg_write with reg_wdata=0x5C and done.
REQ-033 SHALL be verified for STORE: opcode=11, addr=0x10, wdata=0xA5, ack on the 1st cycle -> mem_write for 1 cycle with mem_addr=0x10 and mem_wdata=0xA5, then done; reg_write never asserted.
REQ-034 SHALL be verified for timeout: TIMEOUT=4, LOAD with no ack -> mem_read high for exactly 4 cycles, then err with err_code=10, back in IDLE, and instr_ready=1.
REQ-035 SHALL be verified for boundary ack: TIMEOUT=4, ack on the 4th cycle -> normal completion with no err.
REQ-036 SHALL be verified for NOP and ILLEGAL back-to-back: opcode=01 then 10 -> done, then err with err_code=01; no memory strobes.
REQ-037 SHALL be verified for reset mid-operation: rst_n low during the 2nd RD cycle -> all outputs 0 next cycle, no reg_write or done afterwards, and a new LOAD completes normally.
